// File: rtl/counter_updown_if.sv
`default_nettype none
// ============================================================================
// Module   : counter_updown_if
// Purpose  : Control and status bundle for counter_updown.
// Revision : 1.0
// ============================================================================
interface counter_updown_if #(
   parameter int BITS = 4
);
   logic            enable;
   logic            up;
   logic            load;
   logic [BITS-1:0] load_value;
   logic [BITS-1:0] out;
   logic            wrap;
   logic            at_max;
   logic            at_min;

   modport master (
      output enable, up, load, load_value,
      input  out, wrap, at_max, at_min
   );

   modport slave (
      input  enable, up, load, load_value,
      output out, wrap, at_max, at_min
   );
endinterface
`default_nettype wire

// File: rtl/counter_updown.sv
`default_nettype none
// ============================================================================
// Module   : counter_updown
// Purpose  : Up/down counter with modulus, wrap/saturate ends, load, prescaler.
// Revision : 1.0
// ============================================================================
module counter_updown #(
   parameter int BITS     = 4,
   parameter int MAX      = (1 << BITS) - 1,
   parameter bit SATURATE = 1'b0,
   parameter int PRESCALE = 1
) (
   input  wire logic       clock,
   input  wire logic       reset,
   counter_updown_if.slave bus
);

   localparam int              PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [BITS-1:0] MAX_V    = MAX[BITS-1:0];
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

   if (MAX < 1 || MAX > (1 << BITS) - 1) begin : g_bad_max
      $fatal(1, "counter_updown: MAX out of range 1..2^BITS-1");
   end
   if (PRESCALE < 1) begin : g_bad_prescale
      $fatal(1, "counter_updown: PRESCALE must be >= 1");
   end

   logic [BITS-1:0]  out_r;
   logic             wrap_r;
   logic [PRE_W-1:0] pre;
   logic [BITS-1:0]  step_out;
   logic             step_wrap;

   // Value and wrap flag that a step would produce from the current count.
   always_comb begin
      step_out  = out_r;
      step_wrap = 1'b0;
      if (bus.up) begin
         if (out_r != MAX_V) begin
            step_out = out_r + 1'b1;
         end else if (SATURATE == 1'b0) begin
            step_out  = '0;
            step_wrap = 1'b1;
         end
      end else begin
         if (out_r != '0) begin
            step_out = out_r - 1'b1;
         end else if (SATURATE == 1'b0) begin
            step_out  = MAX_V;
            step_wrap = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         out_r  <= '0;
         pre    <= '0;
         wrap_r <= 1'b0;
      end else if (bus.load) begin
         out_r  <= (bus.load_value > MAX_V) ? MAX_V : bus.load_value;
         pre    <= '0;
         wrap_r <= 1'b0;
      end else if (bus.enable) begin
         if (pre == PRE_LAST) begin
            pre    <= '0;
            out_r  <= step_out;
            wrap_r <= step_wrap;
         end else begin
            pre    <= pre + 1'b1;
            wrap_r <= 1'b0;
         end
      end else begin
         wrap_r <= 1'b0;
      end
   end

   assign bus.out    = out_r;
   assign bus.wrap   = wrap_r;
   assign bus.at_max = (out_r == MAX_V);
   assign bus.at_min = (out_r == '0);

endmodule
`default_nettype wire

// File: tb/tb_counter_updown.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_updown
// Purpose  : Directed checks of counter_updown across four parameter sets.
// Revision : 1.0
// ============================================================================
module tb_counter_updown;

   logic clk = 1'b0;
   logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1, rst_d = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   counter_updown_if #(.BITS(2)) ifa ();
   counter_updown_if #(.BITS(4)) ifb ();
   counter_updown_if #(.BITS(3)) ifc ();
   counter_updown_if #(.BITS(4)) ifd ();

   counter_updown #(.BITS(2)) dut_a (.clock(clk), .reset(rst_a), .bus(ifa));
   counter_updown #(.BITS(4), .MAX(9)) dut_b (.clock(clk), .reset(rst_b), .bus(ifb));
   counter_updown #(.BITS(3), .MAX(5), .SATURATE(1'b1)) dut_c (.clock(clk), .reset(rst_c), .bus(ifc));
   counter_updown #(.BITS(4), .PRESCALE(3)) dut_d (.clock(clk), .reset(rst_d), .bus(ifd));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   int exp_a[5]    = '{1, 2, 3, 0, 1};
   int expw_a[5]   = '{0, 0, 0, 1, 0};
   int exp_b[11]   = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 9};
   int exp_c_up[8] = '{1, 2, 3, 4, 5, 5, 5, 5};
   int exp_c_dn[8] = '{4, 3, 2, 1, 0, 0, 0, 0};
   int en_d[15]    = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
   int exp_d[15]   = '{0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 3, 7, 7, 7, 8};

   initial begin
      {ifa.enable, ifa.up, ifa.load, ifa.load_value} = '0;
      {ifb.enable, ifb.up, ifb.load, ifb.load_value} = '0;
      {ifc.enable, ifc.up, ifc.load, ifc.load_value} = '0;
      {ifd.enable, ifd.up, ifd.load, ifd.load_value} = '0;
      tick();
      tick();
      check("a_reset_out", ifa.out, 0);
      check("a_reset_wrap", ifa.wrap, 0);
      check("a_reset_at_min", ifa.at_min, 1);
      check("a_reset_at_max", ifa.at_max, 0);

      // A: 2-bit wrap counter
      rst_a = 1'b0; ifa.enable = 1'b1; ifa.up = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("a_out[%0d]", i), ifa.out, exp_a[i]);
         check($sformatf("a_wrap[%0d]", i), ifa.wrap, expw_a[i]);
         check($sformatf("a_at_max[%0d]", i), ifa.at_max, (exp_a[i] == 3) ? 1 : 0);
      end
      ifa.enable = 1'b0;

      // B: modulus 10, counting down from reset
      rst_b = 1'b0; ifb.enable = 1'b1; ifb.up = 1'b0;
      for (int i = 0; i < 11; i++) begin
         tick();
         check($sformatf("b_out[%0d]", i), ifb.out, exp_b[i]);
         check($sformatf("b_wrap[%0d]", i), ifb.wrap, (i == 0 || i == 10) ? 1 : 0);
         check($sformatf("b_at_min[%0d]", i), ifb.at_min, (exp_b[i] == 0) ? 1 : 0);
      end
      ifb.enable = 1'b0; ifb.load = 1'b1; ifb.load_value = 4'd12;
      tick();
      check("b_load_clamp", ifb.out, 9);
      check("b_load_clamp_at_max", ifb.at_max, 1);
      ifb.load_value = 4'd3; ifb.enable = 1'b1; ifb.up = 1'b1;
      tick();
      check("b_load_over_enable", ifb.out, 3);
      check("b_load_wrap", ifb.wrap, 0);
      ifb.load = 1'b0;
      for (int i = 4; i <= 7; i++) begin
         tick();
         check($sformatf("b_after_load_%0d", i), ifb.out, i);
      end
      rst_b = 1'b1;
      tick();
      check("b_midreset_out", ifb.out, 0);
      check("b_midreset_wrap", ifb.wrap, 0);
      rst_b = 1'b0;
      tick();
      check("b_resume_out", ifb.out, 1);

      // C: saturating at 5 in both directions
      rst_c = 1'b0; ifc.enable = 1'b1; ifc.up = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         check($sformatf("c_up_out[%0d]", i), ifc.out, exp_c_up[i]);
         check($sformatf("c_up_wrap[%0d]", i), ifc.wrap, 0);
      end
      ifc.up = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         check($sformatf("c_dn_out[%0d]", i), ifc.out, exp_c_dn[i]);
         check($sformatf("c_dn_wrap[%0d]", i), ifc.wrap, 0);
      end
      check("c_at_min", ifc.at_min, 1);

      // D: prescale 3, enable gap after edge 4, load+enable at edge 12
      rst_d = 1'b0; ifd.up = 1'b1;
      for (int i = 0; i < 15; i++) begin
         ifd.enable     = en_d[i][0];
         ifd.load       = (i == 11);
         ifd.load_value = 4'd7;
         tick();
         check($sformatf("d_out_edge%0d", i + 1), ifd.out, exp_d[i]);
         check($sformatf("d_wrap_edge%0d", i + 1), ifd.wrap, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
